fan_alarm_driver: RTL
=====================

// Module: fan_alarm_driver
// PURPOSE
//  Actuator-side consumer of the 3-bit thermal status code E[2:0] from the
//  thermal/button Mealy FSM. Decodes E into a fan PWM drive and a blinking
//  alarm output.
//  Fan duty ramps softly between levels. An emergency code forces full drive
//  at once, followed by a timed cool-down hold. Sits between the FSM and the
//  chip output pins.
// PARAMETERS
//  PWM_BITS   8    PWM counter/duty width; PWM period = 2^PWM_BITS cycles
//  RAMP_DIV   4    clk cycles per 1-LSB duty step while ramping (>=1)
//  DUTY_LO    64   target duty for E=001
//  DUTY_MID   128  target duty for E=010
//  DUTY_HI    192  target duty for E=011
//  BLINK_DIV  8    clk cycles per alarm_out toggle (>=1)
//  HOLD_CYC   32   cycles full duty is held in COOLDOWN after alarm clears
// PORTS
//  clk        in   1         system clock, rising edge
//  rst_n      in   1         asynchronous active-low reset
//  E          in   3         status code: 000 off, 0tt fan level tt, 1xx alarm
//  pwm_out    out  1         fan PWM drive
//  alarm_out  out  1         alarm indicator, blinks in ALARM
//  duty       out  PWM_BITS  current applied duty (observability)
//  state_o    out  2         FSM state: 0 IDLE, 1 RUN, 2 ALARM, 3 COOLDOWN
// BEHAVIOUR
//  - Reset (rst_n=0, async): all outputs 0, state IDLE, code_q=000,
//    all counters 0.
//  - E is registered into code_q every cycle; decisions use code_q, giving
//    1 cycle input latency.
//  - Target: 000->0, 001->DUTY_LO, 010->DUTY_MID, 011->DUTY_HI,
//    1xx (100..111)->MAX. MAX = 2^PWM_BITS-1.
//  - Alarm priority: code_q[2]=1 in any state -> ALARM on the next edge.
//  - IDLE: duty_tgt_int=0. Target!=0 -> RUN, ramp timer cleared.
//  - RUN: ramp timer counts 0..RAMP_DIV-1 and wraps. On wrap, the internal
//    duty moves 1 LSB toward target (up or down); it holds once equal.
//    Target changes mid-ramp redirect the ramp with no reset of the
//    internal duty. Internal duty==0 and target==0 -> IDLE.
//  - ALARM: internal duty=MAX immediately. pwm_out forced 1 combinationally
//    from state (bypasses period latch).
//    alarm_out: 1 on the entry cycle, toggles every BLINK_DIV cycles.
//    code_q[2]=0 -> COOLDOWN; hold counter cleared, alarm_out=0.
//  - COOLDOWN: internal duty held MAX, pwm_out follows normal PWM, and the
//    hold counter increments.
//    code_q[2]=1 -> ALARM (hold counter discarded).
//    Hold counter reaches HOLD_CYC-1 -> RUN; ramp then proceeds down from
//    MAX toward target, or to 0 then IDLE.
//  - PWM: pwm_cnt is free-running PWM_BITS wide and wraps.
//    duty (applied) latches the internal duty only on the cycle
//    pwm_cnt==MAX, so a glitch-free update occurs at period start.
//    pwm_out = (pwm_cnt < duty), except in ALARM where it is 1.
//    duty=0 gives constant 0.
//  - alarm_out is 0 in every state other than ALARM.
//  - Reset mid-operation: immediate return to reset values, including
//    pwm_cnt=0.
//  - All outputs are registered except pwm_out (compare/force of registers).
// TESTING
//  1 reset held 5 cycles, E=000 -> pwm_out=0, alarm_out=0, duty=0,
//    state_o=0 throughout.
//  2 E=001 from IDLE -> state_o=1 two edges later. Internal duty +1 every
//    4 cycles, reaching 64 after 256 cycles.
//    duty output updates only at pwm_cnt==255; pwm high 64/256 once settled.
//  3 Settled at E=011 (192), pulse E=100 for 20 cycles:
//    - state_o=2 within 2 edges; pwm_out=1 continuously.
//    - alarm_out pattern 8 high / 8 low / 4 high.
//    - Then COOLDOWN 32 cycles at duty 255, then RUN ramping 255->192.
//  4 In COOLDOWN at hold count 10, reassert E=110 -> back to ALARM,
//    alarm_out=1. Release -> a full 32-cycle hold restarts.
//  5 E=010 ramping (internal duty 100), switch E=000 -> ramp reverses
//    downward from 100. Reaches 0 after 400 cycles, then state_o=0.
//  6 rst_n low for 1 cycle during ALARM and during RUN -> all outputs 0
//    asynchronously. Resumes from IDLE on release.

Source files
------------

// File: rtl/fan_alarm_driver.sv
// Fan PWM / alarm actuator driven by the 3-bit thermal status code.
// Soft duty ramping, an immediate full-drive alarm with blink, and a timed cool-down hold.
module fan_alarm_driver #(
    parameter int unsigned PWM_BITS  = 8,
    parameter int unsigned RAMP_DIV  = 4,
    parameter int unsigned DUTY_LO   = 64,
    parameter int unsigned DUTY_MID  = 128,
    parameter int unsigned DUTY_HI   = 192,
    parameter int unsigned BLINK_DIV = 8,
    parameter int unsigned HOLD_CYC  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          E,
    output logic                pwm_out,
    output logic                alarm_out,
    output logic [PWM_BITS-1:0] duty,
    output logic [1:0]          state_o
);

    localparam int unsigned RAMP_W  = (RAMP_DIV  > 1) ? $clog2(RAMP_DIV)  : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned HOLD_W  = (HOLD_CYC  > 1) ? $clog2(HOLD_CYC)  : 1;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RUN      = 2'd1;
    localparam logic [1:0] ALARM    = 2'd2;
    localparam logic [1:0] COOLDOWN = 2'd3;

    localparam logic [PWM_BITS-1:0] DUTY_MAX   = {PWM_BITS{1'b1}};
    localparam logic [RAMP_W-1:0]   RAMP_LAST  = RAMP_W'(RAMP_DIV - 1);
    localparam logic [BLINK_W-1:0]  BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST  = HOLD_W'(HOLD_CYC - 1);

    logic [2:0]          code_q;
    logic [1:0]          state, state_nxt;
    logic [PWM_BITS-1:0] duty_int, duty_int_nxt;
    logic [PWM_BITS-1:0] target;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [RAMP_W-1:0]   ramp_cnt, ramp_nxt;
    logic [BLINK_W-1:0]  blink_cnt, blink_nxt;
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
    logic                alarm_nxt;

    // Target duty decoded from the registered status code
    always_comb begin
        target = '0;
        if (code_q[2]) begin
            target = DUTY_MAX;
        end else begin
            case (code_q[1:0])
                2'b01:   target = PWM_BITS'(DUTY_LO);
                2'b10:   target = PWM_BITS'(DUTY_MID);
                2'b11:   target = PWM_BITS'(DUTY_HI);
                default: target = '0;
            endcase
        end
    end

    // State register and all datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q    <= '0;
            state     <= IDLE;
            duty_int  <= '0;
            duty      <= '0;
            pwm_cnt   <= '0;
            ramp_cnt  <= '0;
            blink_cnt <= '0;
            hold_cnt  <= '0;
            alarm_out <= 1'b0;
        end else begin
            code_q    <= E;
            state     <= state_nxt;
            duty_int  <= duty_int_nxt;
            pwm_cnt   <= pwm_cnt + 1'b1;
            ramp_cnt  <= ramp_nxt;
            blink_cnt <= blink_nxt;
            hold_cnt  <= hold_nxt;
            alarm_out <= alarm_nxt;
            // Applied duty only changes at period start to avoid runt pulses
            if (pwm_cnt == DUTY_MAX) begin
                duty <= duty_int;
            end
        end
    end

    // Next-state and next-value logic; alarm code overrides every state
    always_comb begin
        state_nxt    = state;
        duty_int_nxt = duty_int;
        ramp_nxt     = ramp_cnt;
        blink_nxt    = blink_cnt;
        hold_nxt     = hold_cnt;
        alarm_nxt    = alarm_out;

        if (code_q[2]) begin
            state_nxt    = ALARM;
            duty_int_nxt = DUTY_MAX;
            if (state != ALARM) begin
                alarm_nxt = 1'b1;
                blink_nxt = '0;
            end else if (blink_cnt == BLINK_LAST) begin
                alarm_nxt = ~alarm_out;
                blink_nxt = '0;
            end else begin
                blink_nxt = blink_cnt + 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    duty_int_nxt = '0;
                    if (target != '0) begin
                        state_nxt = RUN;
                        ramp_nxt  = '0;
                    end
                end
                RUN: begin
                    if ((duty_int == '0) && (target == '0)) begin
                        state_nxt = IDLE;
                        ramp_nxt  = '0;
                    end else if (ramp_cnt == RAMP_LAST) begin
                        ramp_nxt = '0;
                        if (duty_int < target) begin
                            duty_int_nxt = duty_int + 1'b1;
                        end else if (duty_int > target) begin
                            duty_int_nxt = duty_int - 1'b1;
                        end
                    end else begin
                        ramp_nxt = ramp_cnt + 1'b1;
                    end
                end
                ALARM: begin
                    state_nxt    = COOLDOWN;
                    duty_int_nxt = DUTY_MAX;
                    hold_nxt     = '0;
                    alarm_nxt    = 1'b0;
                end
                COOLDOWN: begin
                    duty_int_nxt = DUTY_MAX;
                    if (hold_cnt == HOLD_LAST) begin
                        state_nxt = RUN;
                        ramp_nxt  = '0;
                    end else begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign state_o = state;
    assign pwm_out = (state == ALARM) | (pwm_cnt < duty);

endmodule
